// File: rtl/rdid_hex_display_if.sv
// Capture bus from the SPI RDID reader: ID strobe, 24-bit ID and a display clear.
interface rdid_hex_display_if;
  logic        id_valid;
  logic [23:0] id_data;
  logic        clear;

  modport master (output id_valid, output id_data, output clear);
  modport slave  (input  id_valid, input  id_data, input  clear);
endinterface

// File: rtl/rdid_hex_display.sv
// Holds the last JEDEC ID and scans it as 6 hex digits on a multiplexed common-anode 7-seg display.
// Optional RDID_MATCH_EN adds id_match and a match/mismatch indicator on digit 6.
module rdid_hex_display #(
  parameter int          DIV_COUNT   = 100000,
  parameter int          CNT_W       = 17,
  parameter logic [23:0] EXPECTED_ID = 24'h20BA18
) (
  input  logic               clk,
  input  logic               reset,
  rdid_hex_display_if.slave  id_bus,
  output logic [7:0]         an,
  output logic [6:0]         seg,
  output logic               dp,
`ifdef RDID_MATCH_EN
  output logic               id_match,
`endif
  output logic               id_held
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_COUNT - 1);
  localparam logic [6:0]       SEG_DASH = 7'b0111111;
  localparam logic [6:0]       SEG_OFF  = 7'h7F;

  logic [0:0]       state;
  logic [23:0]      held_id;
  logic [CNT_W-1:0] div;
  logic [2:0]       digit;
  logic [7:0]       an_nxt;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;
  logic [23:0]      shifted;
  logic [3:0]       nib;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div   <= '0;
      digit <= '0;
    end else if (div == DIV_LAST) begin
      div   <= '0;
      digit <= digit + 3'd1;
    end else begin
      div   <= div + 1'b1;
    end
  end

  // id_valid takes priority over clear so a capture is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_EMPTY;
      held_id <= '0;
    end else if (id_bus.id_valid) begin
      state   <= ST_SHOW;
      held_id <= id_bus.id_data;
    end else if (id_bus.clear) begin
      state   <= ST_EMPTY;
      held_id <= '0;
    end
  end

  assign id_held = (state == ST_SHOW);

`ifdef RDID_MATCH_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) id_match <= 1'b0;
    else       id_match <= (state == ST_SHOW) && (held_id == EXPECTED_ID);
  end
`endif

  always_comb begin
    an_nxt  = 8'hFF;
    seg_nxt = SEG_OFF;
    dp_nxt  = 1'b1;
    shifted = held_id >> {digit, 2'b00};
    nib     = shifted[3:0];
    if (digit < 3'd6) begin
      an_nxt  = ~(8'd1 << digit);
      seg_nxt = (state == ST_SHOW) ? hex7(nib) : SEG_DASH;
    end
`ifdef RDID_MATCH_EN
    if (digit == 3'd6 && state == ST_SHOW) begin
      an_nxt  = 8'hBF;
      seg_nxt = id_match ? hex7(4'h1) : hex7(4'h0);
    end
    if (digit == 3'd0 && id_match) dp_nxt = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= 8'hFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
      dp  <= dp_nxt;
    end
  end

endmodule

// File: tb/tb_rdid_hex_display.sv
// Directed bench for rdid_hex_display with a 4-cycle digit slot.
module tb_rdid_hex_display;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       id_held;
`ifdef RDID_MATCH_EN
  logic       id_match;
`endif
  int n_assert = 0;
  int n_fail   = 0;

  rdid_hex_display_if bus ();

  rdid_hex_display #(.DIV_COUNT(4), .CNT_W(2), .EXPECTED_ID(24'h20BA18)) dut (
    .clk     (clk),
    .reset   (reset),
    .id_bus  (bus.slave),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
`ifdef RDID_MATCH_EN
    .id_match(id_match),
`endif
    .id_held (id_held)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Waits (bounded) until the given anode pattern is on the display; returns at a negedge.
  task automatic wait_an(input string tag, input logic [7:0] pat);
    bit found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (an === pat) found = 1;
      else step(1);
    end
    n_assert++;
    assert (found) else begin
      n_fail++;
      $error("FAIL %s timeout observed_an=%h expected_an=%h", tag, an, pat);
    end
  endtask

  task automatic capture(input logic [23:0] d, input logic clr);
    bus.id_valid = 1'b1;
    bus.id_data  = d;
    bus.clear    = clr;
    step(1);
    bus.id_valid = 1'b0;
    bus.clear    = 1'b0;
  endtask

  localparam logic [7:0] AN_SEQ [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hFF, 8'hFF};

  initial begin
    reset = 1'b1;
    bus.id_valid = 1'b0;
    bus.id_data  = '0;
    bus.clear    = 1'b0;
    step(3);
    check("rst_an", an, 8'hFF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_held", id_held, 1'b0);
    reset = 1'b0;

    // Scan sequence with dashes: sample mid-slot
    step(2);
    for (int s = 0; s < 8; s++) begin
      check($sformatf("scan_an%0d", s), an, AN_SEQ[s]);
      check($sformatf("scan_seg%0d", s), seg, (s < 6) ? 7'b0111111 : 7'h7F);
      step(4);
    end

    // Capture 20BA18: nibbles 8,1,A,B,0,2
    capture(24'h20BA18, 1'b0);
    check("cap_held", id_held, 1'b1);
    step(1);
    wait_an("w_d0", 8'hFE); check("cap_d0", seg, 7'b0000000); check("cap_dp0", dp, 1'b1);
    wait_an("w_d1", 8'hFD); check("cap_d1", seg, 7'b1111001);
    wait_an("w_d2", 8'hFB); check("cap_d2", seg, 7'b0001000);
    wait_an("w_d3", 8'hF7); check("cap_d3", seg, 7'b0000011);
    wait_an("w_d4", 8'hEF); check("cap_d4", seg, 7'b1000000);
    wait_an("w_d5", 8'hDF); check("cap_d5", seg, 7'b0100100);
`ifdef RDID_MATCH_EN
    check("match1", id_match, 1'b1);
    wait_an("w_d6", 8'hBF); check("match_d6", seg, 7'b1111001);
    wait_an("w_m0", 8'hFE); check("match_dp0", dp, 1'b0);
`endif

    // Clear at start of slot 1: scan continues, dashes follow
    wait_an("w_clr", 8'hFD);
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    check("clr_held", id_held, 1'b0);
    check("clr_an_same", an, 8'hFD);
    step(3);
    check("clr_an_next", an, 8'hFB);
    check("clr_seg_dash", seg, 7'b0111111);
`ifdef RDID_MATCH_EN
    check("clr_match", id_match, 1'b0);
`endif

    // Simultaneous clear and id_valid: capture wins
    capture(24'hABCDEF, 1'b1);
    check("both_held", id_held, 1'b1);
    step(1);
    wait_an("w_b0", 8'hFE); check("both_d0", seg, 7'b0001110);
    wait_an("w_b5", 8'hDF); check("both_d5", seg, 7'b0001000);
`ifdef RDID_MATCH_EN
    check("both_match", id_match, 1'b0);
`endif

    // Back-to-back strobes: last one wins
    bus.id_valid = 1'b1;
    bus.id_data  = 24'h111111;
    step(1);
    bus.id_data  = 24'h000003;
    step(1);
    bus.id_valid = 1'b0;
    wait_an("w_bb0", 8'hFE); check("b2b_d0", seg, 7'b0110000);
    wait_an("w_bb1", 8'hFD); check("b2b_d1", seg, 7'b1000000);

`ifdef RDID_MATCH_EN
    capture(24'h20BA17, 1'b0);
    step(1);
    check("mismatch", id_match, 1'b0);
    wait_an("w_mm6", 8'hBF); check("mm_d6", seg, 7'b1000000);
    wait_an("w_mm0", 8'hFE); check("mm_dp0", dp, 1'b1); check("mm_d0", seg, 7'b1111000);
`endif

    // Async reset mid-slot of digit 3 while an ID is held
    wait_an("w_r3", 8'hF7);
    step(1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_an", an, 8'hFF);
    check("mid_rst_seg", seg, 7'h7F);
    check("mid_rst_held", id_held, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step(2);
    check("post_rst_an", an, 8'hFE);
    check("post_rst_seg", seg, 7'b0111111);
    step(4);
    check("post_rst_an1", an, 8'hFD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
